// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

    localparam int KEY_CODE_W = 8;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_e;

endpackage

// File: rtl/keypad_row_sync.sv
// rtl/keypad_row_sync.sv - two-flop synchronizer for the asynchronous keypad rows
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] rows_i,
    output logic [ROWS-1:0] rows_o
);

    logic [ROWS-1:0] meta_q;
    logic [ROWS-1:0] sync_q;

    // Rows idle high (pulled up), so reset to "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= rows_i;
            sync_q <= meta_q;
        end
    end

    assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, frame classification and debounce FSM
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROWS-1:0]       row_in,
    output logic [COLS-1:0]       col_out,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [ROWS-1:0] rows_sync;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      hits_q, hits_d;
    logic [3:0]      code_q, code_d;
    logic [1:0]      acc_hits;
    logic [3:0]      acc_code;
    logic            slot_last, frame_end;
    frame_e          fres;
    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic [3:0]      key_q, key_d;
    logic            valid_q, valid_d;

    keypad_row_sync u_row_sync (
        .clk    (clk),
        .rst    (rst),
        .rows_i (row_in),
        .rows_o (rows_sync)
    );

    assign slot_last = (timer_q == TW'(SCAN_DIV - 1));
    assign frame_end = slot_last && (col_q == 2'd3);
    assign cnt_inc   = cnt_q + CW'(1);

    // Fold this slot's sample into the frame accumulators; hit count saturates at 2.
    always_comb begin
        acc_hits = hits_q;
        acc_code = code_q;
        for (int r = 0; r < ROWS; r++) begin
            if (!rows_sync[r]) begin
                if (acc_hits != 2'd2) acc_hits = acc_hits + 2'd1;
                acc_code = {2'(r), col_q};
            end
        end
        if (acc_hits == 2'd0)      fres = NONE;
        else if (acc_hits == 2'd1) fres = SINGLE;
        else                       fres = MULTI;
    end

    always_comb begin
        timer_d = slot_last ? '0 : timer_q + TW'(1);
        col_d   = slot_last ? col_q + 2'd1 : col_q;
        hits_d  = hits_q;
        code_d  = code_q;
        if (slot_last) begin
            hits_d = frame_end ? 2'd0 : acc_hits;
            code_d = frame_end ? 4'd0 : acc_code;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (fres == SINGLE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_d   = acc_code;
                            valid_d = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cand_d  = acc_code;
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (fres == SINGLE && acc_code == cand_q) begin
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (fres == SINGLE) begin
                        cand_d = acc_code;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (fres == NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (fres == NONE) begin
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            col_q   <= 2'd0;
            hits_q  <= 2'd0;
            code_q  <= 4'd0;
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            key_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            col_q   <= col_d;
            hits_q  <= hits_d;
            code_q  <= code_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign col_out   = ~(COLS'(1) << col_q);
    assign key_code  = {{(KEY_CODE_W - 4){1'b0}}, key_q};
    assign key_valid = valid_q;
    assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    int compared;
    int mismatched;
    int cyc;
    int pulses;
    int last_pulse;
    int consec;
    logic prev_valid;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        if (key_valid) begin
            if (prev_valid) consec++;
            pulses++;
            last_pulse = cyc;
        end
        prev_valid = key_valid;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        cyc        = 0;
        pulses     = 0;
        last_pulse = -1;
        prev_valid = key_valid;
    endtask

    task automatic test_reset();
        keys = 16'h0000;
        do_reset();
        compared++;
        if (col_out !== 4'b1110) begin mismatched++; $display("FAIL reset_col_out: got %b required 1110", col_out); end
        compared++;
        if (key_code !== 8'h00) begin mismatched++; $display("FAIL reset_key_code: got %h required 00", key_code); end
        compared++;
        if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_key_valid: got %b required 0", key_valid); end
        compared++;
        if (key_held !== 1'b0) begin mismatched++; $display("FAIL reset_key_held: got %b required 0", key_held); end
    endtask

    task automatic test_idle();
        int bad_col;
        int held_seen;
        logic [3:0] exp_col;
        bad_col   = 0;
        held_seen = 0;
        keys = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            exp_col = ~(4'b0001 << ((cyc / 4) % 4));
            if (col_out !== exp_col) bad_col++;
            if (key_held !== 1'b0) held_seen++;
            step();
        end
        compared++;
        if (bad_col != 0) begin mismatched++; $display("FAIL idle_col_walk: got %0d wrong cycles required 0", bad_col); end
        compared++;
        if (pulses != 0) begin mismatched++; $display("FAIL idle_no_pulse: got %0d pulses required 0", pulses); end
        compared++;
        if (held_seen != 0) begin mismatched++; $display("FAIL idle_no_held: got %0d held cycles required 0", held_seen); end
    endtask

    task automatic test_clean_press();
        keys = 16'h0200;
        do_reset();
        run_to(47);
        compared++;
        if (key_held !== 1'b0 || pulses != 0) begin
            mismatched++;
            $display("FAIL press_early: got held=%b pulses=%0d required held=0 pulses=0", key_held, pulses);
        end
        run_to(48);
        compared++;
        if (key_valid !== 1'b1) begin mismatched++; $display("FAIL press_valid_48: got %b required 1", key_valid); end
        compared++;
        if (key_code !== 8'h09) begin mismatched++; $display("FAIL press_code: got %h required 09", key_code); end
        compared++;
        if (key_held !== 1'b1) begin mismatched++; $display("FAIL press_held: got %b required 1", key_held); end
        run_to(63);
        compared++;
        if (pulses != 1 || last_pulse != 48) begin
            mismatched++;
            $display("FAIL press_single_pulse: got pulses=%0d last=%0d required 1 at 48", pulses, last_pulse);
        end
    endtask

    task automatic test_release();
        run_to(64);
        keys = 16'h0000;
        run_to(111);
        compared++;
        if (key_held !== 1'b1) begin mismatched++; $display("FAIL release_held_111: got %b required 1", key_held); end
        run_to(112);
        compared++;
        if (key_held !== 1'b0) begin mismatched++; $display("FAIL release_held_112: got %b required 0", key_held); end
        compared++;
        if (key_code !== 8'h09) begin mismatched++; $display("FAIL release_code_kept: got %h required 09", key_code); end
        keys = 16'h8000;
        run_to(170);
        compared++;
        if (pulses != 2 || last_pulse != 160) begin
            mismatched++;
            $display("FAIL second_press_pulse: got pulses=%0d last=%0d required 2 at 160", pulses, last_pulse);
        end
        compared++;
        if (key_code !== 8'h0F) begin mismatched++; $display("FAIL second_press_code: got %h required 0f", key_code); end
    endtask

    task automatic test_bounce();
        keys = 16'h0020;
        do_reset();
        run_to(32);
        keys = 16'h0000;
        run_to(48);
        keys = 16'h0020;
        run_to(110);
        compared++;
        if (pulses != 1 || last_pulse != 96) begin
            mismatched++;
            $display("FAIL bounce_pulse: got pulses=%0d last=%0d required 1 at 96", pulses, last_pulse);
        end
        compared++;
        if (key_code !== 8'h05) begin mismatched++; $display("FAIL bounce_code: got %h required 05", key_code); end
    endtask

    task automatic test_multi();
        keys = 16'h0401;
        do_reset();
        run_to(48);
        compared++;
        if (pulses != 0) begin mismatched++; $display("FAIL multi_no_pulse: got %0d pulses required 0", pulses); end
        keys = 16'h0001;
        run_to(110);
        compared++;
        if (pulses != 1 || last_pulse != 96) begin
            mismatched++;
            $display("FAIL multi_release_pulse: got pulses=%0d last=%0d required 1 at 96", pulses, last_pulse);
        end
        compared++;
        if (key_code !== 8'h00) begin mismatched++; $display("FAIL multi_code: got %h required 00", key_code); end
    endtask

    task automatic test_reset_mid();
        keys = 16'h0008;
        do_reset();
        run_to(40);
        do_reset();
        compared++;
        if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got col=%b valid=%b held=%b required 1110 0 0", col_out, key_valid, key_held);
        end
        run_to(47);
        compared++;
        if (pulses != 0) begin mismatched++; $display("FAIL midreset_early: got %0d pulses required 0", pulses); end
        run_to(60);
        compared++;
        if (pulses != 1 || last_pulse != 48) begin
            mismatched++;
            $display("FAIL midreset_pulse: got pulses=%0d last=%0d required 1 at 48", pulses, last_pulse);
        end
        compared++;
        if (key_code !== 8'h03) begin mismatched++; $display("FAIL midreset_code: got %h required 03", key_code); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        consec     = 0;
        cyc        = 0;
        pulses     = 0;
        last_pulse = -1;
        prev_valid = 1'b0;
        keys       = 16'h0000;
        rst        = 1'b1;
        @(negedge clk);
        test_reset();
        test_idle();
        test_clean_press();
        test_release();
        test_bounce();
        test_multi();
        test_reset_mid();
        compared++;
        if (consec != 0) begin mismatched++; $display("FAIL valid_back_to_back: got %0d repeats required 0", consec); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces it, and emits one 8-bit key code per accepted press.
- The code range is 8'h00..8'h0F (row*4+col). It feeds the calculator's 8-to-4 code converter directly.
- Sits between the board keypad pins and the calculator datapath input stage.

Parameters:
- SCAN_DIV, 4: clock cycles per column slot. Must be >= 4 to cover synchronizer latency plus settling.
- DEBOUNCE_SCANS, 3: consecutive identical scan frames required to accept a press, and to accept a release. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- row_in  in  4  keypad rows, active-low (pulled up), asynchronous to clk.
- col_out  out  4  column drive, active-low, exactly one bit low at any time.
- key_code  out  8  last accepted key, {4'b0000, row[1:0], col[1:0]}.
- key_valid  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high while the accepted key is considered down.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: col_out=4'b1110, key_code=8'h00, key_valid=0, key_held=0. State=IDLE; all counters, the synchronizer and frame accumulators are cleared. Reset mid-scan or mid-press aborts immediately, with no pulse.
- row_in passes through a 2-flop synchronizer; all decisions use the synchronized rows.
- Slot timer counts 0..SCAN_DIV-1. Column index c advances 0->1->2->3->0 when the timer wraps. col_out = ~(4'b0001 << c).
- Sampling:
  - Rows are sampled on the last cycle of each slot (timer==SCAN_DIV-1).
  - Any low row bit r in column c is a hit with code r*4+c.
  - Hits are counted per frame, saturating at 2; the last hit's code is stored.
- Frame = 4 slots (4*SCAN_DIV cycles). At the frame-end cycle (c==3, last slot cycle), the result is classified NONE (0 hits), SINGLE(code) (1 hit) or MULTI (>=2 hits). The accumulators then clear.
- The FSM evaluates only at frame end.
- IDLE:
  - SINGLE(k): cand=k, cnt=1 -> DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately instead.
  - NONE or MULTI: stay in IDLE.
- DEBOUNCE:
  - SINGLE(cand): cnt+1. When the count reaches DEBOUNCE_SCANS, accept: key_code=cand, key_valid=1 on the next cycle only, key_held=1 -> PRESSED.
  - SINGLE(other): cand=other, cnt=1, stay in DEBOUNCE.
  - NONE or MULTI: -> IDLE, no pulse.
- PRESSED:
  - NONE: rcnt=1 -> RELEASE. If DEBOUNCE_SCANS==1, go directly to IDLE with key_held=0.
  - Anything else: stay in PRESSED. A different key or MULTI never generates a new pulse while held.
- RELEASE:
  - NONE: rcnt+1. When the count reaches DEBOUNCE_SCANS -> IDLE, key_held=0 on the next cycle.
  - Any hit: -> PRESSED, rcnt=0.
- key_code holds its value until the next accepted press; it is not cleared on release.
- key_valid never asserts on two consecutive cycles. At most one pulse per press/release cycle.
- Latency: a key stable before a frame starts produces key_valid 1 cycle after the frame end of the DEBOUNCE_SCANS-th clean frame.
- Counter width: $clog2(DEBOUNCE_SCANS+1) bits, with no wrap (the counter stops at the threshold).

Decomposition:
- keypad_pkg contains:
  - State enum {IDLE, DEBOUNCE, PRESSED, RELEASE}.
  - Frame-result enum {NONE, SINGLE, MULTI}.
  - KEY_CODE_W=8.
  - ROWS=4, COLS=4.
- One sub-module: keypad_row_sync, a 4-bit 2-flop synchronizer with synchronous reset to 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; frame=16 cycles; cycle 0 = first cycle after rst drops):
- Idle check: rows all 1 for 200 cycles -> key_valid never 1, key_held=0, and col_out walks 1110,1101,1011,0111, changing every 4 cycles.
- Clean press: row 2 low whenever col_out[1]=0, from cycle 0 -> key_valid pulse at cycle 48 only, key_code=8'h09, key_held=1.
- Release: release after the accepted press -> key_held falls exactly 3 NONE frames later. Pressing key 0x0F afterwards yields key_code=8'h0F with a second pulse.
- Bounce: key 0x05 present for 2 frames, absent for 1, then present for 3 -> exactly one pulse, after the last 3-frame run, with key_code=8'h05.
- Multi-key: keys 0x00 and 0x0A held together -> no pulse. Releasing 0x0A leaves 0x00 only -> pulse 3 frames later with key_code=8'h00.
- Reset mid-debounce: rst for 1 cycle after 2 clean frames of 0x03 -> outputs take reset values, col_out=1110, and 3 full new frames are required before the pulse.
